// File: rtl/pgm_fetch_if.sv
// Bus between the fetch sequencer, the instruction ROM, the Ctrl decoder and the run controller.
// The master modport is the sequencer side; the slave modport is everything around it.
interface pgm_fetch_if #(
    parameter int OPCDE_W = 9,
    parameter int PC_W    = 10,
    parameter int IMD_W   = 5,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [OPCDE_W-1:0] imem_rdata;
    logic [OPCDE_W-1:0] opCde;
    logic               op_vld;
    logic               pgmJmp;
    logic [IMD_W-1:0]   opImd;
    logic               ack;
    logic               busy;
    logic               done;
    logic               pc_wrap;
    logic [CNT_W-1:0]   ret_cnt;

    modport master (
        input  start, start_addr, imem_rdata, pgmJmp, opImd, ack,
        output imem_en, imem_addr, opCde, op_vld, busy, done, pc_wrap, ret_cnt
    );

    modport slave (
        output start, start_addr, imem_rdata, pgmJmp, opImd, ack,
        input  imem_en, imem_addr, opCde, op_vld, busy, done, pc_wrap, ret_cnt
    );
endinterface

// File: rtl/pgm_fetch.sv
// Instruction fetch sequencer: FETCH -> LATCH -> EXEC per instruction, relative branches,
// halt on the done opcode, sticky PC-wrap flag and a saturating retired-instruction count.
module pgm_fetch #(
    parameter int OPCDE_W = 9,
    parameter int PC_W    = 10,
    parameter int IMD_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pgm_fetch_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_DONE
    } state_t;

    // Two guard bits above the PC so a signed step exposes both carry and borrow.
    localparam int EXT_W = PC_W + 2;

    state_t             r_state;
    state_t             w_next;
    logic [PC_W-1:0]    r_pc;
    logic [OPCDE_W-1:0] r_opcde;
    logic               r_pc_wrap;
    logic [CNT_W-1:0]   r_ret_cnt;

    logic [EXT_W-1:0]   w_step;
    logic [EXT_W-1:0]   w_sum;
    logic               w_wrap;
    logic               w_start_ok;

    assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_FETCH;
            S_FETCH: w_next = S_LATCH;
            S_LATCH: w_next = S_EXEC;
            S_EXEC:  w_next = bus.ack ? S_DONE : S_FETCH;
            S_DONE:  if (bus.start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // Next PC: sign-extended branch offset or +1; anything landing outside 0..2^PC_W-1 wrapped.
    always_comb begin
        w_step = bus.pgmJmp ? {{(EXT_W-IMD_W){bus.opImd[IMD_W-1]}}, bus.opImd}
                            : EXT_W'(1);
        w_sum  = {2'b00, r_pc} + w_step;
        w_wrap = |w_sum[EXT_W-1:PC_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_opcde   <= '0;
            r_pc_wrap <= 1'b0;
            r_ret_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_pc      <= bus.start_addr;
                r_pc_wrap <= 1'b0;
                r_ret_cnt <= '0;
            end
            if (r_state == S_LATCH) begin
                r_opcde <= bus.imem_rdata;
            end
            if (r_state == S_EXEC) begin
                if (r_ret_cnt != '1) begin
                    r_ret_cnt <= r_ret_cnt + 1'b1;
                end
                // ack wins over pgmJmp: the PC stays on the done opcode.
                if (!bus.ack) begin
                    r_pc <= w_sum[PC_W-1:0];
                    if (w_wrap) begin
                        r_pc_wrap <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.imem_en   = (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.opCde     = r_opcde;
    assign bus.op_vld    = (r_state == S_EXEC);
    assign bus.busy      = (r_state == S_FETCH) || (r_state == S_LATCH) || (r_state == S_EXEC);
    assign bus.done      = (r_state == S_DONE);
    assign bus.pc_wrap   = r_pc_wrap;
    assign bus.ret_cnt   = r_ret_cnt;
endmodule

// File: tb/tb_pgm_fetch.sv
// Self-checking bench for pgm_fetch: ROM and Ctrl-decoder models around the DUT, with a
// queue of expected fetches (address and word) compared as the DUT issues them.
module tb_pgm_fetch;
    localparam int OPCDE_W = 9;
    localparam int PC_W    = 10;
    localparam int IMD_W   = 5;
    localparam int CNT_W   = 16;

    // Bench opcode encoding: bit8 = done opcode, bit7 = branch, bits4:0 = branch offset.
    localparam logic [8:0] W_DNE = 9'h100;
    localparam logic [8:0] W_A   = 9'h025;
    localparam logic [8:0] W_B   = 9'h04A;
    localparam logic [8:0] W_C   = 9'h013;

    typedef struct {
        logic [PC_W-1:0]    addr;
        logic [OPCDE_W-1:0] word;
    } fetch_t;

    logic clk = 1'b0;
    logic rst_n;
    logic noise_en;
    logic [OPCDE_W-1:0] rom [0:(1<<PC_W)-1];
    fetch_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int dc;

    always #5 clk = ~clk;

    pgm_fetch_if #(.OPCDE_W(OPCDE_W), .PC_W(PC_W), .IMD_W(IMD_W), .CNT_W(CNT_W)) bus ();

    pgm_fetch #(.OPCDE_W(OPCDE_W), .PC_W(PC_W), .IMD_W(IMD_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous ROM: data valid the cycle after imem_en.
    always @(posedge clk) begin
        if (bus.imem_en === 1'b1) bus.imem_rdata <= rom[bus.imem_addr];
    end

    // Ctrl model: decodes opCde while op_vld; outside EXEC, noise_en drives hostile values.
    assign bus.ack    = bus.op_vld ? bus.opCde[8] : noise_en;
    assign bus.pgmJmp = bus.op_vld ? bus.opCde[7] : noise_en;
    assign bus.opImd  = bus.op_vld ? bus.opCde[4:0] : (noise_en ? 5'b10000 : 5'b00000);

    function automatic logic [8:0] jmp(input logic [4:0] imd);
        return 9'h080 | {4'b0000, imd};
    endfunction

    task automatic expect_fetch(input logic [PC_W-1:0] a);
        fetch_t e;
        e.addr = a;
        e.word = rom[a];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [PC_W-1:0] a);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = a;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Starts a program and follows it to DONE; inj>0 pulses a stray start at that cycle.
    task automatic run_prog(input logic [PC_W-1:0] a, input int inj, output int done_cyc);
        int last_fetch = -10;
        logic [OPCDE_W-1:0] cur_word = '0;
        bit finished = 1'b0;
        fetch_t e;
        done_cyc = -1;
        pulse_start(a);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            bus.start = (n == inj);
            if (n == inj) bus.start_addr = 10'h155;
            if (n == 1) begin
                total++;
                if (bus.done !== 1'b0 || bus.ret_cnt !== '0 || bus.pc_wrap !== 1'b0 || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL start_state: done=%b ret_cnt=%0d pc_wrap=%b busy=%b, required 0/0/0/1",
                             bus.done, bus.ret_cnt, bus.pc_wrap, bus.busy);
                end
            end
            if (bus.imem_en === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_fetch: addr=%0d, required no fetch", bus.imem_addr);
                end else begin
                    e = exp_q.pop_front();
                    cur_word   = e.word;
                    last_fetch = n;
                    if (bus.imem_addr !== e.addr) begin
                        bad++;
                        $display("FAIL fetch_addr: got %0d, required %0d", bus.imem_addr, e.addr);
                    end
                end
            end
            total++;
            if (bus.op_vld !== (n == last_fetch + 2)) begin
                bad++;
                $display("FAIL op_vld_timing: cycle %0d op_vld=%b, required %b", n, bus.op_vld, (n == last_fetch + 2));
            end
            if (bus.op_vld === 1'b1) begin
                total++;
                if (bus.opCde !== cur_word) begin
                    bad++;
                    $display("FAIL opcde: got %h, required %h", bus.opCde, cur_word);
                end
            end
            if (bus.done === 1'b1) begin
                done_cyc = n;
                finished = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL timeout: done never rose, required done within 200 cycles");
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_fetch: %0d fetches outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.imem_en, bus.op_vld, bus.busy, bus.done, bus.pc_wrap} !== 5'b0 ||
            bus.ret_cnt !== '0 || bus.opCde !== '0 || bus.imem_addr !== '0) begin
            bad++;
            $display("FAIL reset_init: en=%b vld=%b busy=%b done=%b wrap=%b cnt=%0d op=%h addr=%0d, required all 0",
                     bus.imem_en, bus.op_vld, bus.busy, bus.done, bus.pc_wrap, bus.ret_cnt, bus.opCde, bus.imem_addr);
        end
        rst_n = 1'b1;
        rom[50] = W_A;
        pulse_start(10'd50);
        repeat (3) @(negedge clk);
        total++;
        if (bus.op_vld !== 1'b1) begin
            bad++;
            $display("FAIL reset_reach_exec: op_vld=%b, required 1", bus.op_vld);
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.imem_en, bus.op_vld, bus.busy, bus.done, bus.pc_wrap} !== 5'b0 ||
            bus.ret_cnt !== '0 || bus.opCde !== '0 || bus.imem_addr !== '0) begin
            bad++;
            $display("FAIL reset_mid_exec: en=%b vld=%b busy=%b done=%b wrap=%b cnt=%0d op=%h addr=%0d, required all 0",
                     bus.imem_en, bus.op_vld, bus.busy, bus.done, bus.pc_wrap, bus.ret_cnt, bus.opCde, bus.imem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.imem_en !== 1'b0 || bus.busy !== 1'b0 || bus.op_vld !== 1'b0 || bus.ret_cnt !== '0) begin
            bad++;
            $display("FAIL reset_idle: en=%b busy=%b vld=%b cnt=%0d, required 0/0/0/0",
                     bus.imem_en, bus.busy, bus.op_vld, bus.ret_cnt);
        end
    endtask

    task automatic test_straight_line();
        rom[4] = W_A; rom[5] = W_B; rom[6] = W_C; rom[7] = W_DNE;
        for (int a = 4; a <= 7; a++) expect_fetch(10'(a));
        run_prog(10'd4, 0, dc);
        total++;
        if (dc !== 13) begin
            bad++;
            $display("FAIL straight_done_cycle: got %0d, required 13", dc);
        end
        total++;
        if (bus.ret_cnt !== 16'd4 || bus.busy !== 1'b0 || bus.imem_addr !== 10'd7) begin
            bad++;
            $display("FAIL straight_end: cnt=%0d busy=%b addr=%0d, required 4/0/7", bus.ret_cnt, bus.busy, bus.imem_addr);
        end
    endtask

    task automatic test_branch();
        rom[10] = jmp(5'b11101); rom[7] = W_DNE;
        expect_fetch(10'd10); expect_fetch(10'd7);
        run_prog(10'd10, 0, dc);
        total++;
        if (bus.ret_cnt !== 16'd2 || bus.imem_addr !== 10'd7) begin
            bad++;
            $display("FAIL branch_back: cnt=%0d addr=%0d, required 2/7", bus.ret_cnt, bus.imem_addr);
        end
        rom[10] = jmp(5'b00100); rom[14] = W_DNE;
        expect_fetch(10'd10); expect_fetch(10'd14);
        run_prog(10'd10, 0, dc);
        total++;
        if (bus.imem_addr !== 10'd14 || bus.pc_wrap !== 1'b0) begin
            bad++;
            $display("FAIL branch_fwd: addr=%0d wrap=%b, required 14/0", bus.imem_addr, bus.pc_wrap);
        end
    endtask

    task automatic test_priority_gating();
        rom[20] = 9'h180 | 9'd5;
        expect_fetch(10'd20);
        run_prog(10'd20, 0, dc);
        total++;
        if (bus.imem_addr !== 10'd20 || bus.ret_cnt !== 16'd1 || dc !== 4) begin
            bad++;
            $display("FAIL ack_priority: addr=%0d cnt=%0d done_cyc=%0d, required 20/1/4", bus.imem_addr, bus.ret_cnt, dc);
        end
        rom[30] = W_A; rom[31] = W_B; rom[32] = W_DNE;
        expect_fetch(10'd30); expect_fetch(10'd31); expect_fetch(10'd32);
        noise_en = 1'b1;
        run_prog(10'd30, 0, dc);
        noise_en = 1'b0;
        total++;
        if (bus.ret_cnt !== 16'd3 || dc !== 10) begin
            bad++;
            $display("FAIL gating: cnt=%0d done_cyc=%0d, required 3/10", bus.ret_cnt, dc);
        end
    endtask

    task automatic test_wrap();
        rom[1023] = W_A; rom[0] = W_DNE;
        expect_fetch(10'd1023); expect_fetch(10'd0);
        run_prog(10'd1023, 0, dc);
        total++;
        if (bus.pc_wrap !== 1'b1 || bus.imem_addr !== 10'd0) begin
            bad++;
            $display("FAIL wrap_up: wrap=%b addr=%0d, required 1/0", bus.pc_wrap, bus.imem_addr);
        end
        rom[1] = jmp(5'b11110); rom[1023] = W_DNE;
        expect_fetch(10'd1); expect_fetch(10'd1023);
        run_prog(10'd1, 0, dc);
        total++;
        if (bus.pc_wrap !== 1'b1 || bus.imem_addr !== 10'd1023) begin
            bad++;
            $display("FAIL wrap_down: wrap=%b addr=%0d, required 1/1023", bus.pc_wrap, bus.imem_addr);
        end
        rom[40] = W_DNE;
        expect_fetch(10'd40);
        run_prog(10'd40, 0, dc);
        total++;
        if (bus.pc_wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_clear: wrap=%b, required 0", bus.pc_wrap);
        end
    endtask

    task automatic test_start_handling();
        rom[60] = W_A; rom[61] = W_C; rom[62] = W_DNE;
        for (int inj = 3; inj <= 5; inj++) begin
            expect_fetch(10'd60); expect_fetch(10'd61); expect_fetch(10'd62);
            run_prog(10'd60, inj, dc);
            total++;
            if (bus.ret_cnt !== 16'd3 || dc !== 10) begin
                bad++;
                $display("FAIL busy_start: inj=%0d cnt=%0d done_cyc=%0d, required 3/10", inj, bus.ret_cnt, dc);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        noise_en       = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = W_DNE;
        test_reset();
        test_straight_line();
        test_branch();
        test_priority_gating();
        test_wrap();
        test_start_handling();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
